// File: rtl/ahb_sram_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_slave_if
// Brief    : AHB-Lite bus bundle between the arbiter mux and the SRAM slave
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_sram_slave_if;
   logic        HSEL_P;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [1:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport master (
      output HSEL_P, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL_P, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_slave
// Brief    : AHB-Lite SRAM responder, word-organised array with byte lanes,
//            programmable wait states and two-cycle ERROR responses
// Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
   parameter int unsigned DEPTH       = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int unsigned WAIT_STATES = 0
) (
   input  wire logic        HCLK,
   input  wire logic        HRESETn,
   ahb_sram_slave_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ERR1 = 2'd2,
      S_ERR2 = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             pend_q, pend_d;   // OKAY data phase outstanding
   logic             wr_q, wr_d;
   logic [1:0]       size_q, size_d;
   logic [1:0]       lane_q, lane_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic [31:0]      mem_q [DEPTH];

   logic             w_slot;
   logic             w_accept;
   logic [31:0]      w_offset;
   logic             w_range_err;
   logic             w_align_err;
   logic             w_err;
   logic [IDX_W-1:0] w_idx;
   logic             w_done;
   logic             w_commit;
   logic [3:0]       w_be;
   logic             w_unused;

   // Burst type and the SEQ/NONSEQ distinction do not influence addressing
   assign w_unused = ^{bus.HBURST, bus.HTRANS[0]};

   // New address phases are only taken while this slave is driving HREADYOUT high
   assign w_slot   = (state_q == S_IDLE) || (state_q == S_ERR2);
   assign w_accept = bus.HSEL_P & bus.HREADY & bus.HTRANS[1] & w_slot;

   // Address decode in 32 bits; anything below the base or past the last word errors
   assign w_offset    = bus.HADDR - BASE_ADDR;
   assign w_range_err = (bus.HADDR < BASE_ADDR) || ((w_offset >> 2) >= 32'(DEPTH));
   assign w_align_err = ((bus.HSIZE == 2'd1) && bus.HADDR[0]) ||
                        ((bus.HSIZE == 2'd2) && (bus.HADDR[1:0] != 2'b00));
   assign w_err       = (bus.HSIZE == 2'd3) || w_align_err || w_range_err;
   assign w_idx       = w_offset[IDX_W+1:2];

   // Completion cycle of an OKAY transfer: pending and no longer stalling
   assign w_done   = (state_q == S_IDLE) && pend_q;
   assign w_commit = w_done && wr_q;

   // Little-endian byte-lane enables from the registered size and low address bits
   always_comb begin
      w_be = 4'b0000;
      case (size_q)
         2'd0:    w_be = 4'b0001 << lane_q;
         2'd1:    w_be = lane_q[1] ? 4'b1100 : 4'b0011;
         2'd2:    w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   assign bus.HREADYOUT = w_slot;
   assign bus.HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign bus.HRDATA    = (w_done && !wr_q) ? mem_q[idx_q] : 32'h0;

   // Next-state: capture a new transfer in free slots, count wait states, sequence errors
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      wr_d    = wr_q;
      size_d  = size_q;
      lane_d  = lane_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE, S_ERR2: begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
            if (w_accept) begin
               wr_d   = bus.HWRITE;
               size_d = bus.HSIZE;
               lane_d = bus.HADDR[1:0];
               idx_d  = w_idx;
               if (w_err) begin
                  state_d = S_ERR1;
               end else begin
                  pend_d = 1'b1;
                  if (WS != 4'd0) begin
                     state_d = S_WAIT;
                     cnt_d   = WS;
                  end
               end
            end
         end
         S_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ERR1: begin
            state_d = S_ERR2;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control registers; reset drops any pending transfer so a write cannot commit
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         pend_q  <= 1'b0;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         lane_q  <= 2'd0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         lane_q  <= lane_d;
         idx_q   <= idx_d;
      end
   end

   // SRAM array: enabled byte lanes written on the completion edge of an OKAY write
   always_ff @(posedge HCLK) begin
      if (w_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               mem_q[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_sram_slave
// Brief    : directed bench for ahb_sram_slave, one zero-wait and one
//            two-wait-state instance sharing the stimulus
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;

   logic        HCLK    = 1'b0;
   logic        HRESETn = 1'b1;

   int          dsel       = 0;
   logic        hsel       = 1'b0;
   logic [31:0] haddr      = 32'h0;
   logic        hwrite     = 1'b0;
   logic [1:0]  hsize      = 2'd0;
   logic [1:0]  htrans     = 2'd0;
   logic [31:0] hwdata     = 32'h0;
   logic        hready_blk = 1'b0;

   int          n_total = 0;
   int          n_bad   = 0;

   always #5 HCLK = ~HCLK;

   ahb_sram_slave_if bus0 ();
   ahb_sram_slave_if bus2 ();

   assign bus0.HSEL_P = hsel && (dsel == 0);
   assign bus0.HADDR  = haddr;
   assign bus0.HWRITE = hwrite;
   assign bus0.HSIZE  = hsize;
   assign bus0.HTRANS = htrans;
   assign bus0.HBURST = 3'b001;
   assign bus0.HWDATA = hwdata;
   assign bus0.HREADY = hready_blk ? 1'b0 : bus0.HREADYOUT;

   assign bus2.HSEL_P = hsel && (dsel == 1);
   assign bus2.HADDR  = haddr;
   assign bus2.HWRITE = hwrite;
   assign bus2.HSIZE  = hsize;
   assign bus2.HTRANS = htrans;
   assign bus2.HBURST = 3'b001;
   assign bus2.HWDATA = hwdata;
   assign bus2.HREADY = hready_blk ? 1'b0 : bus2.HREADYOUT;

   ahb_sram_slave #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus0)
   );

   ahb_sram_slave #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_dut2 (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus2)
   );

   function automatic logic [31:0] rdy(input int d);
      return {31'd0, (d == 0) ? bus0.HREADYOUT : bus2.HREADYOUT};
   endfunction

   function automatic logic [31:0] rsp(input int d);
      return {31'd0, (d == 0) ? bus0.HRESP : bus2.HRESP};
   endfunction

   function automatic logic [31:0] rdat(input int d);
      return (d == 0) ? bus0.HRDATA : bus2.HRDATA;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One non-pipelined transfer; returns data/response seen in the final data-phase cycle
   task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [1:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output logic [31:0] rs);
      int n;
      @(negedge HCLK);
      dsel = d; hsel = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = 2'b10;
      @(negedge HCLK);
      hsel = 1'b0; htrans = 2'b00; hwdata = wd;
      n = 0;
      while (rdy(d) == 32'd0 && n < 20) begin
         @(negedge HCLK);
         n++;
      end
      if (n >= 20) check("timeout", rdy(d), 32'd1);
      rd = rdat(d);
      rs = rsp(d);
   endtask

   task automatic wr_ok(input string tag, input int d, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r, s;
      xfer(d, a, 1'b1, sz, wd, r, s);
      check({tag, " resp"}, s, 32'd0);
   endtask

   task automatic rd_ok(input string tag, input int d, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] r, s;
      xfer(d, a, 1'b0, 2'd2, 32'h0, r, s);
      check({tag, " resp"}, s, 32'd0);
      check({tag, " data"}, r, exp);
   endtask

   // Erroring transfer: ERR1 (ready low, ERROR) then ERR2 (ready high, ERROR)
   task automatic err_chk(input string tag, input int d, input logic [31:0] a, input logic w,
                          input logic [1:0] sz, input logic [31:0] wd);
      @(negedge HCLK);
      dsel = d; hsel = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = 2'b10;
      @(negedge HCLK);
      hsel = 1'b0; htrans = 2'b00; hwdata = wd;
      check({tag, " err1 rdy"}, rdy(d), 32'd0);
      check({tag, " err1 resp"}, rsp(d), 32'd1);
      @(negedge HCLK);
      check({tag, " err2 rdy"}, rdy(d), 32'd1);
      check({tag, " err2 resp"}, rsp(d), 32'd1);
      check({tag, " err2 data"}, rdat(d), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #2 HRESETn = 1'b0;
      #2;
      check("rst rdy0", rdy(0), 32'd1);
      check("rst resp0", rsp(0), 32'd0);
      check("rst data0", rdat(0), 32'd0);
      check("rst rdy2", rdy(1), 32'd1);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;

      // Back-to-back write then read of the same word, zero wait states
      @(negedge HCLK);
      dsel = 0; hsel = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 2'd2; htrans = 2'b10;
      @(negedge HCLK);
      check("t1 wr rdy", rdy(0), 32'd1);
      check("t1 wr resp", rsp(0), 32'd0);
      check("t1 wr data", rdat(0), 32'd0);
      hwdata = 32'hDEADBEEF; hwrite = 1'b0;
      @(negedge HCLK);
      check("t1 rd rdy", rdy(0), 32'd1);
      check("t1 rd resp", rsp(0), 32'd0);
      check("t1 rd data", rdat(0), 32'hDEADBEEF);
      hsel = 1'b0; htrans = 2'b00;
      @(negedge HCLK);
      check("t1 idle data", rdat(0), 32'd0);

      // Byte and halfword lanes, other bytes preserved
      wr_ok("t2 w", 0, 32'h10, 2'd2, 32'h11223344);
      wr_ok("t2 b3", 0, 32'h13, 2'd0, 32'hA5EEEEEE);
      rd_ok("t2 r1", 0, 32'h10, 32'hA5223344);
      wr_ok("t2 h1", 0, 32'h12, 2'd1, 32'h7788EEEE);
      rd_ok("t2 r2", 0, 32'h10, 32'h77883344);
      wr_ok("t2 b1", 0, 32'h11, 2'd0, 32'hEEEE66EE);
      rd_ok("t2 r3", 0, 32'h10, 32'h77886644);

      // Two wait states on a read
      wr_ok("t3 w", 1, 32'h4, 2'd2, 32'hCAFEF00D);
      @(negedge HCLK);
      dsel = 1; hsel = 1'b1; haddr = 32'h4; hwrite = 1'b0; hsize = 2'd2; htrans = 2'b10;
      @(negedge HCLK);
      hsel = 1'b0; htrans = 2'b00;
      check("t3 c1 rdy", rdy(1), 32'd0);
      check("t3 c1 data", rdat(1), 32'd0);
      @(negedge HCLK);
      check("t3 c2 rdy", rdy(1), 32'd0);
      check("t3 c2 data", rdat(1), 32'd0);
      @(negedge HCLK);
      check("t3 c3 rdy", rdy(1), 32'd1);
      check("t3 c3 resp", rsp(1), 32'd0);
      check("t3 c3 data", rdat(1), 32'hCAFEF00D);

      // Address range, alignment and size errors leave the array untouched
      wr_ok("t4 w0", 0, 32'h0, 2'd2, 32'h01020304);
      wr_ok("t4 wlast", 0, 32'h3FC, 2'd2, 32'h0F0E0D0C);
      rd_ok("t4 rlast", 0, 32'h3FC, 32'h0F0E0D0C);
      err_chk("t4 range", 0, 32'h400, 1'b1, 2'd2, 32'hBAD0BAD0);
      err_chk("t4 mis word", 0, 32'h2, 1'b1, 2'd2, 32'hFFFFFFFF);
      err_chk("t4 mis half", 0, 32'h1, 1'b1, 2'd1, 32'hFFFFFFFF);
      err_chk("t4 size3", 0, 32'h0, 1'b1, 2'd3, 32'hFFFFFFFF);
      rd_ok("t4 r0", 0, 32'h0, 32'h01020304);
      rd_ok("t4 rlast2", 0, 32'h3FC, 32'h0F0E0D0C);

      // IDLE, BUSY and stalled NONSEQ are not accepted
      @(negedge HCLK);
      dsel = 0; hsel = 1'b1; haddr = 32'h0; hwrite = 1'b1; hsize = 2'd2; htrans = 2'b00;
      hwdata = 32'hFFFFFFFF;
      @(negedge HCLK);
      check("t5 idle rdy", rdy(0), 32'd1);
      check("t5 idle resp", rsp(0), 32'd0);
      htrans = 2'b01;
      @(negedge HCLK);
      check("t5 busy rdy", rdy(0), 32'd1);
      check("t5 busy resp", rsp(0), 32'd0);
      htrans = 2'b10; hready_blk = 1'b1;
      @(negedge HCLK);
      hready_blk = 1'b0; hsel = 1'b0; htrans = 2'b00;
      check("t5 stall rdy", rdy(0), 32'd1);
      check("t5 stall resp", rsp(0), 32'd0);
      @(negedge HCLK);
      check("t5 after rdy", rdy(0), 32'd1);
      rd_ok("t5 r0", 0, 32'h0, 32'h01020304);

      // Reset during the wait phase of a write
      wr_ok("t6 w", 1, 32'h8, 2'd2, 32'h55AA55AA);
      @(negedge HCLK);
      dsel = 1; hsel = 1'b1; haddr = 32'h8; hwrite = 1'b1; hsize = 2'd2; htrans = 2'b10;
      @(negedge HCLK);
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
      check("t6 wait rdy", rdy(1), 32'd0);
      #2 HRESETn = 1'b0;
      #1;
      check("t6 rst rdy", rdy(1), 32'd1);
      check("t6 rst resp", rsp(1), 32'd0);
      check("t6 rst data", rdat(1), 32'd0);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      rd_ok("t6 r8", 1, 32'h8, 32'h55AA55AA);
      rd_ok("t6 r0 keep", 0, 32'h0, 32'h01020304);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
